// File: rtl/mod3_seq_ctrl.sv
// mod3_seq_ctrl: sequencer for a serial divisible-by-3 detector.
// Loads a word on start, clears the detector, feeds it MSB-first one bit per
// tick, then captures the detector verdict and cross-checks it against a
// shadow remainder kept here. A tick enable replaces the old derived slow clock.
`timescale 1ns/1ps

module mod3_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             det_clr,
  output logic             det_step,
  output logic             det_bit,
  input  logic             det_div3,
  output logic             busy,
  output logic             done,
  output logic             div3,
  output logic             err
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL  = BIT_W'(WIDTH);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [1:0]       rem_q,      rem_d;
  logic             div3_q,     div3_d;
  logic             err_q,      err_d;
  logic             tick;

  // Shadow remainder update: (2*r + b) mod 3 for r in {0,1,2}.
  function automatic logic [1:0] rem_next(input logic [1:0] r, input logic b);
    logic [1:0] n;
    unique case ({r, b})
      3'b00_0: n = 2'd0;
      3'b00_1: n = 2'd1;
      3'b01_0: n = 2'd2;
      3'b01_1: n = 2'd0;
      3'b10_0: n = 2'd1;
      3'b10_1: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign tick = (tick_cnt_q == TICK_LAST);

  // Next-state, datapath updates and strobes for the sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rem_d      = rem_q;
    div3_d     = div3_q;
    err_d      = err_q;
    det_clr    = 1'b0;
    det_step   = 1'b0;
    det_bit    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort wins over start when both are high.
        if (start && !abort) begin
          state_d    = S_CLEAR;
          shreg_d    = din;
          bit_cnt_d  = BIT_FULL;
          tick_cnt_d = '0;
          rem_d      = 2'd0;
          div3_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_CLEAR: begin
        busy    = 1'b1;
        det_clr = 1'b1;
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (tick) begin
          det_step  = 1'b1;
          det_bit   = shreg_q[WIDTH-1];
          shreg_d   = shreg_q << 1;
          rem_d     = rem_next(rem_q, shreg_q[WIDTH-1]);
          bit_cnt_d = bit_cnt_q - BIT_ONE;
          if (bit_cnt_q == BIT_ONE) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Detector output is registered, so it already includes the last bit.
          div3_d  = det_div3;
          err_d   = (det_div3 != (rem_q == 2'd0));
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      rem_q      <= 2'd0;
      div3_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      rem_q      <= rem_d;
      div3_q     <= div3_d;
      err_q      <= err_d;
    end
  end

  assign div3 = div3_q;
  assign err  = err_q;

endmodule
